// File: rtl/fifo_new_pkg.sv
// Shared constants and helpers for the fifo_new block.
package fifo_new_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // One extra bit beyond the address acts as the wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_new_ram.sv
// DEPTH x WIDTH storage with one synchronous write port and one registered read port.
module fifo_new_ram
  import fifo_new_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Read data holds unless a read is accepted.
  always_comb begin
    if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read port; a same-address write returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= {WIDTH{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_new.sv
// Synchronous FIFO: pointer, flag and control logic around fifo_new_ram.
module fifo_new
  import fifo_new_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             rd,
  input  logic             wr,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             empty,
  output logic             full
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rd_ok_s;
  logic          wr_ok_s;

  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) && (rd_ptr_q[AW] != wr_ptr_q[AW]);

  // A write into a full FIFO is allowed only when a read frees a slot on the same edge.
  assign rd_ok_s = en && rd && !empty && !reset;
  assign wr_ok_s = en && wr && (!full || rd_ok_s) && !reset;

  // Next-pointer computation; wrap is natural overflow of the PW-bit counter.
  always_comb begin
    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_new_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok_s),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (dataIn),
    .re    (rd_ok_s),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (dataOut)
  );

endmodule

// File: tb/tb_fifo_new.sv
// Scoreboard bench for fifo_new: a behavioural queue model predicts data and flags.
module tb_fifo_new;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk;
  logic             reset;
  logic             en;
  logic             rd;
  logic             wr;
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic             empty;
  logic             full;

  logic [WIDTH-1:0] model[$];
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] last_dout;
  string            phase;
  int               n_vec;
  int               n_err;

  fifo_new #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .rd      (rd),
    .wr      (wr),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .empty   (empty),
    .full    (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic cyc(input logic r, input logic e, input logic rr, input logic ww,
                     input logic [WIDTH-1:0] d);
    bit rd_acc;
    bit wr_acc;
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    reset  = r;
    en     = e;
    rd     = rr;
    wr     = ww;
    dataIn = d;
    @(posedge clk);
    if (r) begin
      model.delete();
      sb.delete();
      last_dout = '0;
    end else if (e) begin
      rd_acc = rr && (model.size() > 0);
      wr_acc = ww && ((model.size() < DEPTH) || rd_acc);
      if (rd_acc) sb.push_back(model.pop_front());
      if (wr_acc) model.push_back(d);
    end
    #1;
    if (rd_acc) last_dout = sb.pop_front();
    check_val("dout", {24'd0, dataOut}, {24'd0, last_dout});
    check_val("empty", {31'd0, empty}, {31'd0, model.size() == 0});
    check_val("full", {31'd0, full}, {31'd0, model.size() == DEPTH});
  endtask

  task automatic wr_word(input logic [WIDTH-1:0] d);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, d);
  endtask

  task automatic rd_word();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    last_dout = '0;
    reset = 1'b1; en = 1'b0; rd = 1'b0; wr = 1'b0; dataIn = '0;

    phase = "reset_idle";
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA);
    rd_word();
    rd_word();

    phase = "ordered";
    wr_word(8'h03); wr_word(8'h05); wr_word(8'h0B); wr_word(8'h02);
    for (int i = 0; i < 4; i++) rd_word();
    rd_word();

    phase = "fill";
    for (int i = 0; i < DEPTH; i++) wr_word(8'h10 + 8'(i));
    wr_word(8'hFF);
    for (int i = 0; i < DEPTH; i++) rd_word();
    rd_word();

    phase = "simul_wrap";
    wr_word(8'h20); wr_word(8'h21);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h22 + 8'(i));
    rd_word(); rd_word();
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h40);
    rd_word();

    phase = "full_simul";
    for (int i = 0; i < DEPTH; i++) wr_word(8'h60 + 8'(i));
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h70);
    for (int i = 0; i < DEPTH; i++) rd_word();

    phase = "mid_reset";
    wr_word(8'h07); wr_word(8'h05);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    wr_word(8'h0B);
    rd_word();

    phase = "enable_hold";
    wr_word(8'h50); wr_word(8'h51);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'(i), 1'(i + 1), 8'hC0 + 8'(i));
    rd_word(); rd_word();

    phase = "random";
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
          1'($urandom), 1'($urandom), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_new.md
FIFO_NEW -- requirements
Module: fifo_new

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of storage words; SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  global enable; when 0, no state changes on that edge.
REQ-006 rd  input  1  read request, qualified by en.
REQ-007 wr  input  1  write request, qualified by en.
REQ-008 dataIn  input  WIDTH  write data, sampled on the rising edge when a write is accepted.
REQ-009 dataOut  output  WIDTH  registered read data.
REQ-010 empty  output  1  high when the FIFO holds zero words.
REQ-011 full  output  1  high when the FIFO holds DEPTH words.

Function
REQ-012 The block SHALL be a first-in first-out buffer; words are read in exactly the order written.
REQ-013 A write SHALL be accepted on an edge when en=1, wr=1 and reset=0, and either full=0 or a read is accepted on the same edge.
- Accepted write: stores dataIn at the write pointer and advances the write pointer modulo DEPTH.
REQ-014 A read SHALL be accepted on an edge when en=1, rd=1, reset=0 and empty=0.
- Accepted read: loads the word at the read pointer into dataOut and advances the read pointer modulo DEPTH.
- Read latency: dataOut is valid one clock after the accepting edge.
REQ-015 dataOut SHALL hold its previous value on every edge without an accepted read, including rd=1 while empty.
REQ-016 Write while full without a simultaneous read SHALL be ignored; stored data and pointers stay unchanged.
REQ-017 Simultaneous rd=1 and wr=1 while empty SHALL perform the write only; there is no write-to-read bypass.
REQ-018 Simultaneous rd=1 and wr=1 while neither empty nor full SHALL perform both operations; occupancy is unchanged.
REQ-019 Simultaneous rd=1 and wr=1 while full SHALL perform both; the read returns the oldest word and full stays 1.
REQ-020 Pointers SHALL be log2(DEPTH)+1 bits, with the MSB acting as a wrap bit.
- empty = (read pointer == write pointer).
- full = (low bits equal) and (wrap bits differ).
REQ-021 empty and full SHALL be derived combinationally from the registered pointers, so they update in the cycle after the causing edge.
REQ-022 Wrap-around SHALL be seamless: a write or read past address DEPTH-1 continues at address 0.
REQ-023 When en=0, all pointers, storage and dataOut SHALL hold their values regardless of rd and wr.

Reset
REQ-024 On a rising edge with reset=1, independent of en:
- both pointers clear to 0;
- dataOut clears to 0;
- empty becomes 1 and full becomes 0.
REQ-025 Reset SHALL take priority over rd, wr and en on the same edge. Storage contents are not cleared and are unreachable until rewritten.
REQ-026 Reset asserted mid-operation SHALL discard all stored words; the first word written after reset is the first word read.

Structure
REQ-027 A shared package fifo_new_pkg SHALL hold the default WIDTH and DEPTH constants and the pointer-width function (clog2(DEPTH)+1).
REQ-028 Storage SHALL be one sub-module, fifo_new_ram, a DEPTH x WIDTH array with one synchronous write port and one synchronous read port.
- The pointer, flag and control logic stays in fifo_new.

Verification
REQ-029 Reset then idle: reset=1 for 2 cycles -> empty=1, full=0, dataOut=0x00; rd=1 on empty -> dataOut stays 0x00.
REQ-030 Ordered transfer: write 0x03,0x05,0x0B,0x02, then read 4 -> dataOut 0x03,0x05,0x0B,0x02, each one cycle after its read edge; empty=1 afterwards.
REQ-031 Fill and overflow:
- write DEPTH words 0x10..0x17 -> full=1 after the 8th edge;
- a further write of 0xFF is ignored;
- 8 reads return 0x10..0x17 and then empty=1.
REQ-032 Simultaneous rd/wr and wrap: with 2 words queued, assert rd=wr=1 for 10 cycles with incrementing data -> occupancy stays 2, order preserved across the pointer wrap.
- Then rd=wr=1 while empty -> write only, dataOut unchanged.
REQ-033 Reset mid-operation:
- write 0x07,0x05, assert reset for 2 cycles with rd=1 -> empty=1, dataOut=0x00;
- write 0x0B and read it -> dataOut=0x0B.
REQ-034 Enable hold: with en=0, toggle rd/wr for 5 cycles -> flags, dataOut and queue contents unchanged.
